// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU with a valid/ready handshake on both sides.
// ADD, XOR and AND finish one cycle after accept. SRA is bit-serial: one
// arithmetic right shift per cycle, so it takes 1+amount cycles to finish.
// The result register is held under backpressure until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_sra_step;
  logic [SHW-1:0]   w_amt;

  // Only the low log2(WIDTH) bits of op_b form the shift amount.
  assign w_amt      = op_b[SHW-1:0];
  // One arithmetic step: replicate the sign bit into the vacated MSB.
  assign w_sra_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};

  // Value loaded into the result register on accept; SRA starts from op_a.
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // any path that left w_alu_res unassigned would infer a latch.
    w_alu_res = op_a;
    case (ALUOp)
      OP_ADD:  w_alu_res = op_a + op_b;
      OP_XOR:  w_alu_res = op_a ^ op_b;
      OP_AND:  w_alu_res = op_a & op_b;
      OP_SRA:  w_alu_res = op_a;
      default: w_alu_res = op_a;
    endcase
  end

  // Control FSM plus the result, zero flag and shift counter registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is tested first so it overrides accept, shift and handshake
    // in the same cycle; every register here is sequential, so all updates
    // use non-blocking assignments.
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            if (ALUOp == OP_SRA) begin
              r_cnt <= w_amt;
              if (w_amt == '0) r_state <= DONE;
              else             r_state <= SHIFT;
            end else begin
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          r_result <= w_sra_step;
          r_zero   <= (w_sra_step == '0);
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) r_state <= DONE;
        end
        DONE: begin
          // No accept here: a new request waits for IDLE, one op in flight.
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit (WIDTH=32): a table of directed vectors with
// hand-computed results and latencies, followed by hand-written sequences
// for backpressure and reset during a shift.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready high; measure latency, check the result and
  // that the handshake completes in the first DONE cycle.
  task automatic run_op(input vec_t v);
    int cycles;
    @(negedge clk);
    check({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    ALUOp     = v.op;
    op_a      = v.a;
    op_b      = v.b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ALUOp    = ~v.op;
    op_a     = ~v.a;
    op_b     = ~v.b;
    check({v.name, ".busy"}, 32'(busy), 32'd1);
    cycles = 1;
    while (!out_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check({v.name, ".latency"}, 32'(cycles), 32'(v.lat));
    check({v.name, ".result"}, result, v.res);
    check({v.name, ".zero"}, 32'(zero), 32'(v.z));
    @(negedge clk);
    check({v.name, ".post_out_valid"}, 32'(out_valid), 32'd0);
    check({v.name, ".post_in_ready"}, 32'(in_ready), 32'd1);
    check({v.name, ".post_result_held"}, result, v.res);
  endtask

  initial begin
    int cycles;
    rst       = 1'b1;
    in_valid  = 1'b0;
    ALUOp     = 2'b00;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;

    vecs.push_back('{"add_wrap",  2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1});
    vecs.push_back('{"add_basic", 2'b00, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1});
    vecs.push_back('{"xor_pat",   2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1});
    vecs.push_back('{"and_pat",   2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
    vecs.push_back('{"and_zero",  2'b10, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1});
    vecs.push_back('{"xor_self",  2'b01, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, 1});
    vecs.push_back('{"add_msb",   2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1});
    vecs.push_back('{"sra_4",     2'b11, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 5});
    vecs.push_back('{"sra_amt0",  2'b11, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0, 1});
    vecs.push_back('{"sra_hibits",2'b11, 32'h000000F0, 32'hFFFFFF04, 32'h0000000F, 1'b0, 5});
    vecs.push_back('{"sra_31pos", 2'b11, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 1'b1, 32});
    vecs.push_back('{"sra_31neg", 2'b11, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{"add_after", 2'b00, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.result",    result,         32'h0);
    check("rst.zero",      32'(zero),      32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: hold the result for 10 cycles while a new request is offered.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ALUOp     = 2'b00;
    op_a      = 32'h00000005;
    op_b      = 32'h00000007;
    @(negedge clk);
    op_a   = 32'h00000000;
    op_b   = 32'h00000000;
    ALUOp  = 2'b10;
    cycles = 1;
    while (!out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("bp.latency", 32'(cycles), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.result",    result,         32'h0000000C);
      check("bp.zero",      32'(zero),      32'd0);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_out_valid", 32'(out_valid), 32'd0);
    check("bp.release_in_ready",  32'(in_ready),  32'd1);
    check("bp.release_result",    result,         32'h0000000C);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.no_accept_on_consume", 32'(busy), 32'd0);

    // Reset during SHIFT of 0x40000000 by 31.
    @(negedge clk);
    in_valid = 1'b1;
    ALUOp    = 2'b11;
    op_a     = 32'h40000000;
    op_b     = 32'h0000001F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid.busy",      32'(busy),      32'd1);
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.in_ready",  32'(in_ready),  32'd1);
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.busy",      32'(busy),      32'd0);
    check("rstmid.result",    result,         32'h0);
    check("rstmid.zero",      32'(zero),      32'd1);
    repeat (3) @(negedge clk);
    check("rstmid.stay_idle", 32'(out_valid), 32'd0);

    // The unit is still usable after an aborted shift.
    run_op('{"post_rst_xor", 2'b01, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (power of two, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port ALUOp  input  2  operation code from the ALU decoder: 00 ADD, 01 XOR, 10 AND, 11 SRA.
REQ-007 SHALL have port op_a  input  WIDTH  first operand; SRA shift source.
REQ-008 SHALL have port op_b  input  WIDTH  second operand; SRA shift amount is op_b[log2(WIDTH)-1:0].
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered operation result.
REQ-012 SHALL have port zero  output  1  registered flag, 1 when result equals 0.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on a cycle where in_valid and in_ready are both 1; ALUOp, op_a, op_b sampled only on that edge.
REQ-017 SHALL, on accept with ALUOp 00/01/10, load result with op_a+op_b (mod 2^WIDTH, carry discarded) / op_a XOR op_b / op_a AND op_b and go to DONE; out_valid high on the next cycle (latency 1).
REQ-018 SHALL, on accept with ALUOp 11, load result with op_a and a shift counter with the shift amount; go to DONE if amount is 0, else SHIFT.
REQ-019 SHALL, in SHIFT, each cycle shift result right 1 bit replicating result[WIDTH-1] and decrement the counter; go to DONE on the cycle the counter reaches 0, giving out_valid exactly 1+amount cycles after accept.
REQ-020 SHALL ignore op_b bits above the shift-amount field for SRA.
REQ-021 SHALL update zero together with result on every result load or shift step.
REQ-022 SHALL hold result, zero and out_valid stable in DONE while out_ready = 0 (no data loss under backpressure).
REQ-023 SHALL return to IDLE on the edge where out_valid and out_ready are both 1; result and zero keep their last value in IDLE.
REQ-024 SHALL NOT accept a new request in the same cycle a result is consumed (one operation in flight; max throughput one op per 2 cycles).
REQ-025 SHALL ignore in_valid and input changes while in SHIFT or DONE.
REQ-026 SHALL, if out_ready is already high when DONE is entered, complete the handshake in that first DONE cycle.

Reset
REQ-027 SHALL, on a rising edge with rst = 1, force state IDLE, result = 0, zero = 1, shift counter = 0, overriding any other event that cycle.
REQ-028 SHALL therefore present in_ready = 1, out_valid = 0, busy = 0 after reset.
REQ-029 SHALL abort an in-progress SHIFT or pending DONE on reset, discarding the partial/held result without asserting out_valid.

Verification
REQ-030 SHALL verify ADD: WIDTH=32, op_a=0xFFFFFFFF, op_b=0x00000001, ALUOp=00, out_ready=1 -> next cycle out_valid=1, result=0x00000000, zero=1.
REQ-031 SHALL verify XOR/AND: op_a=0xF0F0F0F0, op_b=0xFF00FF00 -> ALUOp 01 gives 0x0FF00FF0, ALUOp 10 gives 0xF000F000, each 1 cycle after accept.
REQ-032 SHALL verify SRA: op_a=0x80000000, op_b=0x00000004 -> busy 4 cycles in SHIFT, out_valid 5 cycles after accept, result=0xF8000000; op_b=0x00000020 (amount 0) -> result=0x80000000 after 1 cycle.
REQ-033 SHALL verify backpressure: out_ready=0 for 10 cycles in DONE -> result/zero/out_valid unchanged, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL verify reset mid-operation: rst=1 during SHIFT of op_a=0x40000000 by 31 -> next cycle IDLE, result=0, zero=1, out_valid=0, in_ready=1.
